// File: rtl/vu_pkg.sv
// Shared definitions for the VU LED frame transmitter: state encoding,
// pixel width and the default WS2812 timing constants.
package vu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        LATCH
    } state_t;

    localparam int PIX_W = 24;

    localparam int DEF_NUM_LEDS    = 20;
    localparam int DEF_ADDR        = 256;
    localparam int DEF_T0H_CYC     = 4;
    localparam int DEF_T1H_CYC     = 8;
    localparam int DEF_BIT_CYC     = 15;
    localparam int DEF_RES_CYC     = 960;
    localparam int DEF_PEAK_FRAMES = 16;

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit WS2812 waveform generator: a strobe starts one BIT_CYC-long
// symbol that is high for T0H_CYC or T1H_CYC cycles and low for the rest.
// o_bit_done marks the last cycle of the symbol, so a strobe in that cycle
// continues into the next bit with no gap.
module ws2812_bit_tx
    import vu_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_strobe,
    input  logic i_bit,
    output logic o_dout,
    output logic o_bit_done
);

    localparam int CW = $clog2(BIT_CYC);

    logic          active;
    logic [CW-1:0] cyc;
    logic [CW-1:0] high_len;

    assign o_bit_done = active && (cyc == CW'(BIT_CYC - 1));

    // Symbol timer and registered line driver; cycle 0 of every symbol is high.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // updates from values sampled before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active   <= 1'b0;
            cyc      <= '0;
            high_len <= '0;
            o_dout   <= 1'b0;
        end else if (i_strobe) begin
            active   <= 1'b1;
            cyc      <= '0;
            high_len <= i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
            o_dout   <= 1'b1;
        end else if (active) begin
            if (o_bit_done) begin
                active <= 1'b0;
                cyc    <= '0;
                o_dout <= 1'b0;
            end else begin
                cyc    <= cyc + CW'(1);
                o_dout <= (cyc + CW'(1)) < high_len;
            end
        end
    end

endmodule

// File: rtl/vu_led_tx.sv
// VU meter LED frame transmitter. Per accepted start it reads one GRB word
// per LED from the colour ROM (prefetching the next word during bit 0 of the
// current LED), blanks LEDs at or above the latched level, serialises the
// frame MSB first through ws2812_bit_tx and closes with a low latch gap.
// Optional build macro VU_PEAK_HOLD_EN adds a decaying peak-hold LED.
module vu_led_tx
    import vu_pkg::*;
#(
    parameter int NUM_LEDS    = DEF_NUM_LEDS,
    parameter int ADDR        = DEF_ADDR,
    parameter int T0H_CYC     = DEF_T0H_CYC,
    parameter int T1H_CYC     = DEF_T1H_CYC,
    parameter int BIT_CYC     = DEF_BIT_CYC,
    parameter int RES_CYC     = DEF_RES_CYC,
    parameter int PEAK_FRAMES = DEF_PEAK_FRAMES
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [$clog2(NUM_LEDS+1)-1:0] i_level,
    output logic [$clog2(ADDR)-1:0]     o_addr,
    output logic                        o_ren,
    input  logic [PIX_W-1:0]            i_data,
    output logic                        o_dout,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int AW  = $clog2(ADDR);
    localparam int LW  = $clog2(NUM_LEDS + 1);
    localparam int RW  = $clog2(RES_CYC);
    localparam int BW  = $clog2(PIX_W);
    localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);
    localparam logic [BW-1:0] MSB_IDX  = BW'(PIX_W - 1);

    state_t           state, state_next;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_clamped;
    logic [LW-1:0]    pix_idx;
    logic [LW-1:0]    pix_nxt;
    logic [BW-1:0]    bit_idx;
    logic [PIX_W-1:0] cur_word;
    logic [PIX_W-1:0] next_word;
    logic             rd_pend;
    logic [RW-1:0]    lat_cnt;

    logic             ren_next;
    logic [AW-1:0]    addr_next;
    logic             done_next;
    logic             strobe;
    logic             bit_val;
    logic             bit_done;

    logic             peak_first;
    logic             peak_next;
    logic             lit_first;
    logic             lit_next;

    assign level_clamped = (i_level > LW'(NUM_LEDS)) ? LW'(NUM_LEDS) : i_level;
    assign pix_nxt       = pix_idx + LW'(1);
    assign o_busy        = (state != IDLE);

`ifdef VU_PEAK_HOLD_EN
    localparam int FW = $clog2(PEAK_FRAMES + 1);

    logic [LW-1:0] peak_q;
    logic [FW-1:0] frame_cnt;

    assign peak_first = (peak_q == LW'(1));
    assign peak_next  = (peak_q != '0) && (pix_nxt == peak_q - LW'(1));

    // Peak rises to any larger latched level and decays one step every
    // PEAK_FRAMES completed frames, but never below the level just shown.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            peak_q    <= '0;
            frame_cnt <= '0;
        end else if (state == IDLE && i_start) begin
            if (level_clamped > peak_q) peak_q <= level_clamped;
        end else if (state == LATCH && done_next) begin
            if (frame_cnt == FW'(PEAK_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (peak_q > level_q) peak_q <= peak_q - LW'(1);
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end
`else
    // Only consumed by the peak-hold build.
    localparam int unused_peak_frames = PEAK_FRAMES;

    assign peak_first = 1'b0;
    assign peak_next  = 1'b0;
`endif

    // LED 0 is decided in WAIT; LED k+1 is decided while its word is prefetched.
    assign lit_first = (level_q != '0) || peak_first;
    assign lit_next  = (pix_nxt < level_q) || peak_next;

    ws2812_bit_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_tx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_strobe   (strobe),
        .i_bit      (bit_val),
        .o_dout     (o_dout),
        .o_bit_done (bit_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, ROM request, bit strobes and done pulse.
    // NOTE: every signal is given a default before the case so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ren_next   = 1'b0;
        addr_next  = o_addr;
        done_next  = 1'b0;
        strobe     = 1'b0;
        bit_val    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = FETCH;
                    ren_next   = 1'b1;
                    addr_next  = '0;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                state_next = SEND;
                strobe     = 1'b1;
                bit_val    = lit_first & i_data[PIX_W-1];
            end
            SEND: begin
                if (bit_done) begin
                    if (bit_idx != '0) begin
                        strobe  = 1'b1;
                        bit_val = cur_word[bit_idx - BW'(1)];
                        if (bit_idx == BW'(1) && pix_idx != LAST_LED) begin
                            ren_next  = 1'b1;
                            addr_next = AW'(pix_nxt);
                        end
                    end else if (pix_idx != LAST_LED) begin
                        strobe  = 1'b1;
                        bit_val = next_word[PIX_W-1];
                    end else begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                if (lat_cnt == RW'(RES_CYC - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered ROM interface and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ren  <= 1'b0;
            o_addr <= '0;
            o_done <= 1'b0;
        end else begin
            o_ren  <= ren_next;
            o_addr <= addr_next;
            o_done <= done_next;
        end
    end

    // Frame datapath: level latch, word capture, pixel/bit indices, latch timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q   <= '0;
            pix_idx   <= '0;
            bit_idx   <= '0;
            cur_word  <= '0;
            next_word <= '0;
            rd_pend   <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            rd_pend <= o_ren;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        level_q <= level_clamped;
                        pix_idx <= '0;
                    end
                end
                WAIT: begin
                    cur_word <= lit_first ? i_data : '0;
                    bit_idx  <= MSB_IDX;
                end
                SEND: begin
                    if (rd_pend) next_word <= lit_next ? i_data : '0;
                    if (bit_done) begin
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - BW'(1);
                        end else if (pix_idx != LAST_LED) begin
                            pix_idx  <= pix_nxt;
                            cur_word <= next_word;
                            bit_idx  <= MSB_IDX;
                        end else begin
                            lat_cnt <= '0;
                        end
                    end
                end
                LATCH: lat_cnt <= lat_cnt + RW'(1);
                default: ;
            endcase
        end
    end

endmodule
